// File: rtl/tdes_if.sv
// -----------------------------------------------------------------------------
// tdes_if
// Bundles the host-side and DES-core-side signals of the Triple-DES sequencer.
//
// Host side:
//   start, decrypt, key1..key3, block_in  : one block operation request
//   iv, iv_load                           : CBC chain seed (CBC builds only)
//   block_out, done, error, busy          : result and status
// Core side:
//   des_start, des_decrypt, des_key, des_in : one single-DES pass
//   des_done, des_out                       : pass completion and result
//
// Modports:
//   slave  : the sequencer itself
//   master : the environment (host plus DES core)
// -----------------------------------------------------------------------------
interface tdes_if;
    logic        start;
    logic        decrypt;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;
    logic [63:0] block_in;
    logic [63:0] iv;
    logic        iv_load;
    logic [63:0] block_out;
    logic        done;
    logic        error;
    logic        busy;
    logic        des_start;
    logic        des_decrypt;
    logic [63:0] des_key;
    logic [63:0] des_in;
    logic        des_done;
    logic [63:0] des_out;

    modport slave (
        input  start, decrypt, key1, key2, key3, block_in, iv, iv_load,
        input  des_done, des_out,
        output block_out, done, error, busy,
        output des_start, des_decrypt, des_key, des_in
    );

    modport master (
        output start, decrypt, key1, key2, key3, block_in, iv, iv_load,
        output des_done, des_out,
        input  block_out, done, error, busy,
        input  des_start, des_decrypt, des_key, des_in
    );
endinterface

// File: rtl/tdes_sequencer.sv
// -----------------------------------------------------------------------------
// tdes_sequencer
// Runs a single-pass DES core three times to perform one Triple-DES (EDE)
// block operation. Encrypt order: (K1,enc) (K2,dec) (K3,enc); decrypt order:
// (K3,dec) (K2,enc) (K1,dec). A per-pass watchdog aborts the operation with
// error=1 if the core does not answer within WAIT_LIMIT wait cycles.
//
// Parameters:
//   WAIT_LIMIT : max wait cycles per pass before abort (0 disables watchdog)
// Ports:
//   clk        : system clock
//   n_rst      : synchronous active-low reset
//   bus        : tdes_if.slave (host request/result and DES core handshake)
// Build option:
//   TDES_CBC_EN : when defined, adds a 64-bit CBC chain register loaded from
//                 iv by iv_load in IDLE. Undefined: ECB only, iv/iv_load unused.
//
// All outputs are registered; they are computed from the next state so that
// des_start is high in the LAUNCH cycles and done in the DONE cycle.
// -----------------------------------------------------------------------------
module tdes_sequencer #(
    parameter int unsigned WAIT_LIMIT = 32'd255
) (
    input  logic  clk,
    input  logic  n_rst,
    tdes_if.slave bus
);

    localparam int unsigned CNT_W = (WAIT_LIMIT < 32'd2) ? 32'd1 : $clog2(WAIT_LIMIT + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_LIMIT == 32'd0) ? 32'd0 : WAIT_LIMIT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic WDOG_EN = (WAIT_LIMIT != 32'd0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH1 = 3'd1,
        WAIT1   = 3'd2,
        LAUNCH2 = 3'd3,
        WAIT2   = 3'd4,
        LAUNCH3 = 3'd5,
        WAIT3   = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [63:0]      key1_r;
    logic [63:0]      key2_r;
    logic [63:0]      key3_r;
    logic             dec_r;
    logic [63:0]      block_out_r;
    logic             done_r;
    logic             error_r;
    logic             busy_r;
    logic             des_start_r;
    logic             des_decrypt_r;
    logic [63:0]      des_key_r;
    logic [63:0]      des_in_r;
    logic [63:0]      key_s;
    logic             dir_s;
    logic [63:0]      din_s;
    logic [63:0]      out_s;
    logic             err_s;
    logic             timeout_s;
    logic             launch_s;
    logic [63:0]      pass1_in_s;
    logic [63:0]      final_out_s;

    // The counter holds the number of wait cycles already spent in this pass;
    // the last allowed wait cycle is WAIT_LIMIT-1.
    assign timeout_s = WDOG_EN && (cnt_r == CNT_LAST);
    assign launch_s  = (state_s == LAUNCH1) || (state_s == LAUNCH2) || (state_s == LAUNCH3);

`ifdef TDES_CBC_EN
    logic [63:0] chain_r;
    logic [63:0] blk_r;
    logic [63:0] iv_eff_s;

    // CBC data shaping: a same-cycle iv_load feeds the new iv straight into pass 1.
    always_comb begin
        if (bus.iv_load) begin
            iv_eff_s = bus.iv;
        end else begin
            iv_eff_s = chain_r;
        end
        if (bus.decrypt) begin
            pass1_in_s = bus.block_in;
        end else begin
            pass1_in_s = bus.block_in ^ iv_eff_s;
        end
        if (dec_r) begin
            final_out_s = bus.des_out ^ chain_r;
        end else begin
            final_out_s = bus.des_out;
        end
    end

    // Chain register and the original ciphertext kept for decrypt chaining.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            chain_r <= 64'd0;
            blk_r   <= 64'd0;
        end else begin
            if ((state_r == IDLE) && bus.iv_load) begin
                chain_r <= bus.iv;
            end else if ((state_r == WAIT3) && bus.des_done) begin
                chain_r <= dec_r ? blk_r : bus.des_out;
            end else begin
                chain_r <= chain_r;
            end
            if ((state_r == IDLE) && bus.start) begin
                blk_r <= bus.block_in;
            end else begin
                blk_r <= blk_r;
            end
        end
    end
`else
    logic unused_cbc_s;

    assign unused_cbc_s = ^{bus.iv, bus.iv_load};

    // ECB: data passes through unchanged at both ends.
    always_comb begin
        pass1_in_s  = bus.block_in;
        final_out_s = bus.des_out;
    end
`endif

    // Next-state logic plus the per-pass key/direction/data selection.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        key_s   = des_key_r;
        dir_s   = des_decrypt_r;
        din_s   = des_in_r;
        out_s   = block_out_r;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = LAUNCH1;
                    key_s   = bus.decrypt ? bus.key3 : bus.key1;
                    dir_s   = bus.decrypt;
                    din_s   = pass1_in_s;
                end else begin
                    state_s = IDLE;
                end
            end
            LAUNCH1: begin
                state_s = WAIT1;
                cnt_s   = CNT_ZERO;
            end
            WAIT1: begin
                if (bus.des_done) begin
                    state_s = LAUNCH2;
                    key_s   = key2_r;
                    dir_s   = ~dec_r;
                    din_s   = bus.des_out;
                end else if (timeout_s) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            LAUNCH2: begin
                state_s = WAIT2;
                cnt_s   = CNT_ZERO;
            end
            WAIT2: begin
                if (bus.des_done) begin
                    state_s = LAUNCH3;
                    key_s   = dec_r ? key1_r : key3_r;
                    dir_s   = dec_r;
                    din_s   = bus.des_out;
                end else if (timeout_s) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            LAUNCH3: begin
                state_s = WAIT3;
                cnt_s   = CNT_ZERO;
            end
            WAIT3: begin
                if (bus.des_done) begin
                    state_s = DONE;
                    out_s   = final_out_s;
                end else if (timeout_s) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            key1_r        <= 64'd0;
            key2_r        <= 64'd0;
            key3_r        <= 64'd0;
            dec_r         <= 1'b0;
            block_out_r   <= 64'd0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            busy_r        <= 1'b0;
            des_start_r   <= 1'b0;
            des_decrypt_r <= 1'b0;
            des_key_r     <= 64'd0;
            des_in_r      <= 64'd0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            if ((state_r == IDLE) && bus.start) begin
                key1_r <= bus.key1;
                key2_r <= bus.key2;
                key3_r <= bus.key3;
                dec_r  <= bus.decrypt;
            end else begin
                key1_r <= key1_r;
                key2_r <= key2_r;
                key3_r <= key3_r;
                dec_r  <= dec_r;
            end
            block_out_r   <= out_s;
            done_r        <= (state_s == DONE);
            error_r       <= err_s;
            busy_r        <= (state_s != IDLE);
            des_start_r   <= launch_s;
            des_decrypt_r <= dir_s;
            des_key_r     <= key_s;
            des_in_r      <= din_s;
        end
    end

    assign bus.block_out   = block_out_r;
    assign bus.done        = done_r;
    assign bus.error       = error_r;
    assign bus.busy        = busy_r;
    assign bus.des_start   = des_start_r;
    assign bus.des_decrypt = des_decrypt_r;
    assign bus.des_key     = des_key_r;
    assign bus.des_in      = des_in_r;

endmodule

// File: tb/tb_tdes_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tdes_sequencer
// Directed bench for tdes_sequencer (WAIT_LIMIT=8) with an XOR model core
// (des_out = des_in ^ des_key after a programmable latency). Expected passes
// and results are queued when an operation is issued and compared when the
// DUT launches a pass or raises done.
// -----------------------------------------------------------------------------
module tb_tdes_sequencer;

    typedef struct packed {
        logic [63:0] key;
        logic        dir;
        logic [63:0] din;
    } pass_t;

    typedef struct packed {
        logic [63:0] out;
        logic        err;
    } res_t;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    tdes_if bus();

    tdes_sequencer #(.WAIT_LIMIT(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int done_cnt = 0;

    pass_t pass_q[$];
    res_t  res_q[$];
    logic [63:0] last_out_m = 64'd0;
    logic [63:0] chain_m = 64'd0;

    // model core state
    int          core_lat = 1;
    logic        core_mute = 1'b0;
    logic        core_done_r = 1'b0;
    logic [63:0] core_out_r = 64'd0;
    logic [63:0] core_val_r = 64'd0;
    int          core_cnt_r = 0;
    logic        core_busy_r = 1'b0;
    logic        inj_done = 1'b0;
    logic [63:0] inj_out = 64'd0;

    assign bus.des_done = core_done_r | inj_done;
    assign bus.des_out  = inj_done ? inj_out : core_out_r;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // XOR model core with latency core_lat (>= 1)
    always @(posedge clk) begin
        core_done_r <= 1'b0;
        if (bus.des_start === 1'b1 && !core_mute) begin
            if (core_lat == 1) begin
                core_done_r <= 1'b1;
                core_out_r  <= bus.des_in ^ bus.des_key;
                core_busy_r <= 1'b0;
            end else begin
                core_busy_r <= 1'b1;
                core_cnt_r  <= core_lat - 1;
                core_val_r  <= bus.des_in ^ bus.des_key;
            end
        end else if (core_busy_r) begin
            if (core_cnt_r == 1) begin
                core_done_r <= 1'b1;
                core_out_r  <= core_val_r;
                core_busy_r <= 1'b0;
            end else begin
                core_cnt_r <= core_cnt_r - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_block_out"}, bus.block_out, 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_error"}, 64'(bus.error), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_des_start"}, 64'(bus.des_start), 64'd0);
        check({tag, "_des_decrypt"}, 64'(bus.des_decrypt), 64'd0);
        check({tag, "_des_key"}, bus.des_key, 64'd0);
        check({tag, "_des_in"}, bus.des_in, 64'd0);
    endtask

    // Queue expected passes and result for one operation (XOR core model).
    task automatic push_op(input logic dec, input logic [63:0] blk, input logic [63:0] k1,
                           input logic [63:0] k2, input logic [63:0] k3, input logic abort);
        logic [63:0] ka, kb, kc, d, r;
        ka = dec ? k3 : k1;
        kb = k2;
        kc = dec ? k1 : k3;
        d  = blk;
`ifdef TDES_CBC_EN
        if (!dec) d = blk ^ chain_m;
`endif
        pass_q.push_back('{ka, dec, d});
        if (abort) begin
            res_q.push_back('{last_out_m, 1'b1});
        end else begin
            pass_q.push_back('{kb, ~dec, d ^ ka});
            pass_q.push_back('{kc, dec, d ^ ka ^ kb});
            r = d ^ ka ^ kb ^ kc;
`ifdef TDES_CBC_EN
            if (dec) begin
                r = r ^ chain_m;
                chain_m = blk;
            end else begin
                chain_m = r;
            end
`endif
            last_out_m = r;
            res_q.push_back('{r, 1'b0});
        end
    endtask

    // Drive one start pulse; returns the cycle number of cycle 0.
    task automatic launch(input logic dec, input logic [63:0] blk, input logic [63:0] k1,
                          input logic [63:0] k2, input logic [63:0] k3, input logic abort,
                          output int t0);
        push_op(dec, blk, k1, k2, k3, abort);
        bus.decrypt  = dec;
        bus.block_in = blk;
        bus.key1     = k1;
        bus.key2     = k2;
        bus.key3     = k3;
        bus.start    = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.iv_load = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int exp_lat, input string tag);
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
        check({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
        check({tag, "_held_out"}, bus.block_out, last_out_m);
    endtask

    // Monitor: compare launched passes and completed results with the queues.
    initial begin : monitor
        pass_t p;
        res_t  rr;
        forever begin
            @(negedge clk);
            if (bus.des_start === 1'b1) begin
                start_cnt++;
                check("pass_expected", 64'(pass_q.size() > 0), 64'd1);
                if (pass_q.size() > 0) begin
                    p = pass_q.pop_front();
                    check("pass_key", bus.des_key, p.key);
                    check("pass_dir", 64'(bus.des_decrypt), 64'(p.dir));
                    check("pass_din", bus.des_in, p.din);
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                check("result_expected", 64'(res_q.size() > 0), 64'd1);
                if (res_q.size() > 0) begin
                    rr = res_q.pop_front();
                    check("result_out", bus.block_out, rr.out);
                    check("result_err", 64'(bus.error), 64'(rr.err));
                end
            end
        end
    end

    initial begin : stimulus
        int t0;
        int s0;
        int d0;
        n_rst        = 1'b0;
        bus.start    = 1'b0;
        bus.decrypt  = 1'b0;
        bus.key1     = 64'd0;
        bus.key2     = 64'd0;
        bus.key3     = 64'd0;
        bus.block_in = 64'd0;
        bus.iv       = 64'd0;
        bus.iv_load  = 1'b0;

        // reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        n_rst = 1'b1;
        inj_out  = 64'hDEAD_BEEF_0BAD_F00D;
        inj_done = 1'b1;
        @(posedge clk);
        #1;
        inj_done = 1'b0;
        @(posedge clk);
        #1;
        check_idle("idle_des_done");

        // ECB encrypt, D=1
        core_lat = 1;
        launch(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hAAAA_AAAA_AAAA_AAAA,
               64'h5555_5555_5555_5555, 1'b0, t0);
        wait_done(t0, 7, "ecb_enc");
        check("ecb_enc_value", bus.block_out, 64'h0000_0000_0000_0000);

        // ECB decrypt of the previous result restores the plaintext
        launch(1'b1, 64'h0000_0000_0000_0000, 64'd0, 64'hAAAA_AAAA_AAAA_AAAA,
               64'h5555_5555_5555_5555, 1'b0, t0);
        wait_done(t0, 7, "ecb_dec_rt");
        check("ecb_dec_rt_value", bus.block_out, 64'hFFFF_FFFF_FFFF_FFFF);

        // ECB decrypt, pattern block
        launch(1'b1, 64'h0123_4567_89AB_CDEF, 64'd0, 64'hAAAA_AAAA_AAAA_AAAA,
               64'h5555_5555_5555_5555, 1'b0, t0);
        wait_done(t0, 7, "ecb_dec");

        // D=5 core, stray start during WAIT2
        core_lat = 5;
        s0 = start_cnt;
        launch(1'b0, 64'h1357_9BDF_0246_8ACE, 64'h0F0F_0F0F_0F0F_0F0F,
               64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, t0);
        repeat (8) @(posedge clk);
        #1;
        check("wait2_busy", 64'(bus.busy), 64'd1);
        bus.block_in = 64'hCAFE_CAFE_CAFE_CAFE;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(t0, 19, "d5");
        repeat (4) @(posedge clk);
        #1;
        check("d5_start_pulses", 64'(start_cnt - s0), 64'd3);

        // watchdog: core never answers
        core_mute = 1'b1;
        s0 = start_cnt;
        launch(1'b0, 64'h5A5A_5A5A_5A5A_5A5A, 64'd1, 64'd2, 64'd3, 1'b1, t0);
        wait_done(t0, 10, "wdog");
        check("wdog_start_pulses", 64'(start_cnt - s0), 64'd1);
        core_mute = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset during WAIT2 of the next operation
        s0 = start_cnt;
        d0 = done_cnt;
        launch(1'b0, 64'h0F1E_2D3C_4B5A_6978, 64'd7, 64'd8, 64'd9, 1'b0, t0);
        repeat (8) @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("mid_reset");
        n_rst = 1'b1;
        pass_q.delete();
        res_q.delete();
        last_out_m = 64'd0;
        chain_m    = 64'd0;
        repeat (10) @(posedge clk);
        #1;
        check("late_done_busy", 64'(bus.busy), 64'd0);
        check("late_done_count", 64'(done_cnt - d0), 64'd0);
        check("mid_reset_starts", 64'(start_cnt - s0), 64'd2);
        check("late_done_out", bus.block_out, 64'd0);
        core_lat = 1;

`ifdef TDES_CBC_EN
        // CBC: load iv, encrypt two blocks
        bus.iv      = 64'h1111_1111_1111_1111;
        bus.iv_load = 1'b1;
        chain_m     = 64'h1111_1111_1111_1111;
        @(posedge clk);
        #1;
        bus.iv_load = 1'b0;
        launch(1'b0, 64'h2222_2222_2222_2222, 64'd0, 64'd0, 64'd0, 1'b0, t0);
        bus.iv      = 64'hFFFF_0000_FFFF_0000;
        bus.iv_load = 1'b1;
        wait_done(t0, 7, "cbc_enc1");
        bus.iv_load = 1'b0;
        check("cbc_enc1_value", bus.block_out, 64'h3333_3333_3333_3333);
        launch(1'b0, 64'h4444_4444_4444_4444, 64'd0, 64'd0, 64'd0, 1'b0, t0);
        wait_done(t0, 7, "cbc_enc2");
        check("cbc_enc2_value", bus.block_out, 64'h7777_7777_7777_7777);
        // CBC decrypt with iv loaded in the start cycle
        bus.iv      = 64'h1111_1111_1111_1111;
        bus.iv_load = 1'b1;
        chain_m     = 64'h1111_1111_1111_1111;
        launch(1'b1, 64'h3333_3333_3333_3333, 64'd0, 64'd0, 64'd0, 1'b0, t0);
        wait_done(t0, 7, "cbc_dec1");
        check("cbc_dec1_value", bus.block_out, 64'h2222_2222_2222_2222);
        launch(1'b1, 64'h7777_7777_7777_7777, 64'd0, 64'd0, 64'd0, 1'b0, t0);
        wait_done(t0, 7, "cbc_dec2");
        check("cbc_dec2_value", bus.block_out, 64'h4444_4444_4444_4444);
`else
        // ECB: iv and iv_load have no effect
        bus.iv      = 64'h1111_1111_1111_1111;
        bus.iv_load = 1'b1;
        launch(1'b0, 64'h2222_2222_2222_2222, 64'd0, 64'd0, 64'd0, 1'b0, t0);
        wait_done(t0, 7, "ecb_iv");
        check("ecb_iv_value", bus.block_out, 64'h2222_2222_2222_2222);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("pass_q_empty", 64'(pass_q.size()), 64'd0);
        check("res_q_empty", 64'(res_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
